// File: rtl/load_align_unit_pkg.sv
// Shared encodings for the load align unit: access sizes, FSM states and timeout counter width.
package load_align_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } state_t;

    // Reserved size 2'b11 is rejected like any other misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offset[0];
            SZ_WORD: mis = (offset != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align_unit_lane_extend.sv
// Selects the byte/halfword lane of a returned memory word and sign- or zero-extends it.
module lane_extend
    import load_align_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        unSign,
    output logic [31:0] result
);

    logic [1:0]  byte_lane;
    logic        half_hi;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        // Big-endian byte k lives in lane 3-k, which is ~k for a 2-bit index.
        byte_lane = BIG_ENDIAN ? ~offset : offset;
        half_hi   = BIG_ENDIAN ? ~offset[1] : offset[1];
        byte_val  = rdata[8*byte_lane +: 8];
        half_val  = half_hi ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: result = {{24{byte_val[7] & ~unSign}}, byte_val};
            SZ_HALF: result = {{16{half_val[15] & ~unSign}}, half_val};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load unit: issues a word-aligned read over req/gnt/rvalid, then aligns and extends the result.
// state | meaning
// IDLE  | waiting for start; request fields are latched here
// REQ   | mem_req high until the memory grants it
// WAIT  | granted, counting cycles until rvalid or timeout
// RESP  | one-cycle done (and err on misalign/timeout)
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        unSign,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [1:0]       lat_off;
    logic [1:0]       lat_size;
    logic             lat_uns;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      ext_data;

    lane_extend #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane_extend (
        .rdata  (mem_rdata),
        .offset (lat_off),
        .size   (lat_size),
        .unSign (lat_uns),
        .result (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lat_off  <= '0;
            lat_size <= '0;
            lat_uns  <= 1'b0;
            cnt      <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lat_off  <= addr[1:0];
                        lat_size <= size;
                        lat_uns  <= unSign;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        if (is_misaligned(size, addr[1:0])) begin
                            state    <= RESP;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            data_out <= '0;
                        end else begin
                            state    <= REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= {addr[31:2], 2'b00};
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_rvalid) begin
                            state    <= RESP;
                            done     <= 1'b1;
                            data_out <= ext_data;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // rvalid wins over the timeout when both land in the same cycle.
                    if (mem_rvalid) begin
                        state    <= RESP;
                        done     <= 1'b1;
                        data_out <= ext_data;
                    end else if (cnt == CNT_LAST) begin
                        state    <= RESP;
                        done     <= 1'b1;
                        err      <= 1'b1;
                        data_out <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
